// File: rtl/tiny16_bus_pkg.sv
// Shared definitions for the tiny16 strobe-bus initiator: state encoding and timing defaults.
package tiny16_bus_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } bus_state_e;

  localparam int unsigned DefAddrWidth    = 16;
  localparam int unsigned DefDataWidth    = 16;
  localparam int unsigned DefSetupCycles  = 1;
  localparam int unsigned DefStrobeCycles = 2;
  localparam int unsigned DefHoldCycles   = 1;
  localparam int unsigned DefWaitTimeout  = 15;

  localparam logic StrobeInactive = 1'b1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tiny16_bus_master.sv
// tiny16 strobe-bus initiator: one valid/ready request becomes one SETUP/STROBE/HOLD bus cycle.
// Optional TINY16_BUS_WAIT_EN adds bus_nwait strobe extension with a timeout error response.
module tiny16_bus_master
  import tiny16_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DefAddrWidth,
  parameter int unsigned DATA_WIDTH    = DefDataWidth,
  parameter int unsigned SETUP_CYCLES  = DefSetupCycles,
  parameter int unsigned STROBE_CYCLES = DefStrobeCycles,
  parameter int unsigned HOLD_CYCLES   = DefHoldCycles
`ifdef TINY16_BUS_WAIT_EN
  ,
  parameter int unsigned WAIT_TIMEOUT  = DefWaitTimeout
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_nrd,
  output logic                  bus_nwr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
`ifdef TINY16_BUS_WAIT_EN
  input  logic                  bus_nwait,
`endif
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int unsigned CntW =
      $clog2(max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES)) + 1;

  if (SETUP_CYCLES == 0 || STROBE_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_param_check
    $fatal(1, "tiny16_bus_master: every phase length must be at least one cycle");
  end

  bus_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic            accept;
  logic            phase_done;
  logic            wait_ext;
  logic            strobe_end;
  logic            hold_end;
  logic            capture_ok;

  assign req_ready  = (state_q == StIdle);
  assign accept     = req_valid && req_ready;
  assign phase_done = (cnt_q == '0);

`ifdef TINY16_BUS_WAIT_EN
  localparam int unsigned WaitW = $clog2(WAIT_TIMEOUT + 1) + 1;

  logic [WaitW-1:0] wait_cnt_q;
  logic             err_q;
  logic             wait_timeout;

  // Extension only counts on the last strobe cycle; one more low cycle past the limit aborts.
  assign wait_ext     = !bus_nwait && (wait_cnt_q != WaitW'(WAIT_TIMEOUT));
  assign wait_timeout = !bus_nwait && (wait_cnt_q == WaitW'(WAIT_TIMEOUT));
  assign capture_ok   = !we_q && !wait_timeout;
`else
  assign wait_ext   = 1'b0;
  assign capture_ok = !we_q;
  assign resp_error = 1'b0;
`endif

  assign strobe_end = (state_q == StStrobe) && phase_done && !wait_ext;
  assign hold_end   = (state_q == StHold) && phase_done;

  always_ff @(posedge clk) begin : fsm
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
`ifdef TINY16_BUS_WAIT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StSetup;
            cnt_q   <= CntW'(SETUP_CYCLES - 1);
            we_q    <= req_we;
          end
        end
        StSetup: begin
          if (phase_done) begin
            state_q <= StStrobe;
            cnt_q   <= CntW'(STROBE_CYCLES - 1);
`ifdef TINY16_BUS_WAIT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StStrobe: begin
          if (!phase_done) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (wait_ext) begin
`ifdef TINY16_BUS_WAIT_EN
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end else begin
            state_q <= StHold;
            cnt_q   <= CntW'(HOLD_CYCLES - 1);
`ifdef TINY16_BUS_WAIT_EN
            err_q   <= wait_timeout;
`endif
          end
        end
        StHold: begin
          if (phase_done) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin : out_regs
    if (reset) begin
      bus_nrd     <= StrobeInactive;
      bus_nwr     <= StrobeInactive;
      bus_address <= '0;
      bus_wdata   <= '0;
      resp_rdata  <= '0;
      resp_valid  <= 1'b0;
`ifdef TINY16_BUS_WAIT_EN
      resp_error  <= 1'b0;
`endif
    end else begin
      resp_valid <= hold_end;
`ifdef TINY16_BUS_WAIT_EN
      resp_error <= hold_end && err_q;
`endif
      if (accept) begin
        bus_address <= req_addr;
        if (req_we) begin
          bus_wdata <= req_wdata;
        end
      end
      if ((state_q == StSetup) && phase_done) begin
        bus_nrd <= we_q;
        bus_nwr <= !we_q;
      end else if (strobe_end) begin
        bus_nrd <= StrobeInactive;
        bus_nwr <= StrobeInactive;
        if (capture_ok) begin
          resp_rdata <= bus_rdata;
        end
      end
    end
  end

endmodule
